// File: rtl/mp_control_unit.sv
// -----------------------------------------------------------------------------
// mp_control_unit
//
// Control unit for a small 16-bit microprogrammed processor. It fetches an
// instruction word from a combinationally addressed program ROM, decodes it,
// sequences multi-cycle MUL/DIV operations and drives the register-file write
// strobe. It also computes the next program counter (sequential, JMP, CMPJ)
// and latches a sticky halt when HLT retires.
//
// State table:
//   state | meaning
//   IF    | fetch: wait for run, latch ir from rom_data
//   FD    | decode: ir fields are stable, arm first-EX flag
//   EX    | execute: launch MUL/DIV and wait for alu_done, capture CMPJ flag
//   RWB   | write back: wr_en pulse, pc update, HLT sets halted
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous, active-low reset
//   run        in   start/continue enable, only looked at in IF
//   rom_data   in   16-bit instruction word addressed by pc
//   cmp_eq     in   datapath equality flag (RA == RB)
//   alu_done   in   MUL/DIV result valid
//   state      out  current FSM state (IF=0, FD=1, EX=2, RWB=3)
//   pc         out  program counter / ROM address
//   ir         out  latched instruction
//   opcode     out  ir[15:12]
//   ra/rb/rd   out  ir[11:8] / ir[7:4] / ir[3:0]
//   imm        out  ir[7:0]
//   imm_sel    out  ALU B operand selects imm (LDI, ADI)
//   alu_start  out  one-cycle MUL/DIV launch pulse
//   wr_en      out  register-file write strobe
//   wr_addr    out  register-file write address
//   halted     out  sticky halt flag
// -----------------------------------------------------------------------------
module mp_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] rom_data,
    input  logic        cmp_eq,
    input  logic        alu_done,
    output logic [1:0]  state,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  rd,
    output logic [7:0]  imm,
    output logic        imm_sel,
    output logic        alu_start,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IF  = 2'd0,
        S_FD  = 2'd1,
        S_EX  = 2'd2,
        S_RWB = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ADI  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_COMP = 4'hC;
    localparam logic [3:0] OP_CMPJ = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        taken_q, taken_d;
    logic        halted_q, halted_d;
    logic        ex_first_q, ex_first_d;

    logic        is_muldiv;
    logic        is_imm;
    logic        is_write;
    logic [7:0]  rd_sext;

    // Field decode straight off the latched instruction.
    assign opcode = ir_q[15:12];
    assign ra     = ir_q[11:8];
    assign rb     = ir_q[7:4];
    assign rd     = ir_q[3:0];
    assign imm    = ir_q[7:0];

    assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_imm    = (opcode == OP_LDI) || (opcode == OP_ADI);
    // Opcodes 1..C all write a result register.
    assign is_write  = (opcode != OP_NOP) && (opcode <= OP_COMP);
    // CMPJ branch offset is rd as a 4-bit two's complement value.
    assign rd_sext   = {{4{rd[3]}}, rd};

    assign imm_sel = is_imm;
    assign wr_addr = is_imm ? ra : rd;

    assign state  = state_q;
    assign pc     = pc_q;
    assign ir     = ir_q;
    assign halted = halted_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IF;
            pc_q       <= 8'h00;
            ir_q       <= 16'h0000;
            taken_q    <= 1'b0;
            halted_q   <= 1'b0;
            ex_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            taken_q    <= taken_d;
            halted_q   <= halted_d;
            ex_first_q <= ex_first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        taken_d    = taken_q;
        halted_d   = halted_q;
        ex_first_d = ex_first_q;
        alu_start  = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            S_IF: begin
                if (run && !halted_q) begin
                    ir_d    = rom_data;
                    state_d = S_FD;
                end
            end

            S_FD: begin
                ex_first_d = 1'b1;
                state_d    = S_EX;
            end

            S_EX: begin
                ex_first_d = 1'b0;
                if (is_muldiv) begin
                    // Launch only on entry; alu_done may already be high then.
                    alu_start = ex_first_q;
                    if (alu_done) begin
                        state_d = S_RWB;
                    end
                end else begin
                    if (opcode == OP_CMPJ) begin
                        taken_d = cmp_eq;
                    end
                    state_d = S_RWB;
                end
            end

            S_RWB: begin
                wr_en   = is_write;
                state_d = S_IF;
                case (opcode)
                    OP_JMP:  pc_d = imm;
                    OP_CMPJ: pc_d = taken_q ? (pc_q + rd_sext) : (pc_q + 8'd1);
                    // pc stays on the HLT so a debugger sees where it stopped.
                    OP_HLT:  halted_d = 1'b1;
                    default: pc_d = pc_q + 8'd1;
                endcase
            end

            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mp_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mp_control_unit
//
// Directed bench for mp_control_unit. Stimulus writes instructions into a ROM
// model and pushes the hand-computed retirement record of each one into a
// queue; a monitor on the falling edge pops and compares as the DUT walks
// through FD (ir), RWB (write strobe, address, EX length, launches) and the
// following IF (next pc, halted).
// -----------------------------------------------------------------------------
module tb_mp_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] rom_data;
    logic        cmp_eq;
    logic        alu_done = 1'b0;
    logic [1:0]  state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode, ra, rb, rd;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        alu_start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        halted;

    logic [15:0] rom [256];
    assign rom_data = rom[pc];

    mp_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rom_data  (rom_data),
        .cmp_eq    (cmp_eq),
        .alu_done  (alu_done),
        .state     (state),
        .pc        (pc),
        .ir        (ir),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .rd        (rd),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .alu_start (alu_start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        int          wr_cnt;
        logic [3:0]  wr_addr;
        logic        imm_sel;
        int          ex_cycles;
        int          starts;
        logic [7:0]  next_pc;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [7:0] addr, input logic [15:0] word, input int wrc,
                        input logic [3:0] wa, input logic isel, input int exc,
                        input int stc, input logic [7:0] npc, input logic hlt);
        exp_t e;
        rom[addr]   = word;
        e.ir        = word;
        e.wr_cnt    = wrc;
        e.wr_addr   = wa;
        e.imm_sel   = isel;
        e.ex_cycles = exc;
        e.starts    = stc;
        e.next_pc   = npc;
        e.halted    = hlt;
        exp_q.push_back(e);
    endtask

    // MUL/DIV model: answers three cycles after the launch pulse.
    bit done_en  = 1'b1;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            done_cnt = 0;
            alu_done = 1'b0;
        end else if (alu_start && done_en) begin
            done_cnt = 3;
            alu_done = 1'b0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            alu_done = (done_cnt == 0);
        end else begin
            alu_done = 1'b0;
        end
    end

    // Monitor / scoreboard.
    int ex_cnt  = 0;
    int st_cnt  = 0;
    int wr_cnt  = 0;
    bit wait_pc = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            ex_cnt  = 0;
            st_cnt  = 0;
            wr_cnt  = 0;
            wait_pc = 1'b0;
        end else begin
            if (alu_start) st_cnt++;
            if (wr_en)     wr_cnt++;
            case (state)
                2'd1: begin
                    if (exp_q.size() == 0) fail_now($sformatf("unexpected_fetch ir=0x%h", ir));
                    else check("fd_ir", ir, exp_q[0].ir);
                end
                2'd2: ex_cnt++;
                2'd3: begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_rwb");
                    end else begin
                        check("rwb_wr_en_cycles", wr_cnt, exp_q[0].wr_cnt);
                        if (exp_q[0].wr_cnt != 0) check("rwb_wr_addr", wr_addr, exp_q[0].wr_addr);
                        check("rwb_imm_sel", imm_sel, exp_q[0].imm_sel);
                        check("rwb_imm", imm, exp_q[0].ir[7:0]);
                        check("ex_cycles", ex_cnt, exp_q[0].ex_cycles);
                        check("alu_start_pulses", st_cnt, exp_q[0].starts);
                        wait_pc = 1'b1;
                    end
                end
                default: begin
                    if (wait_pc && exp_q.size() > 0) begin
                        check("next_pc", pc, exp_q[0].next_pc);
                        check("halted", halted, exp_q[0].halted);
                        void'(exp_q.pop_front());
                        wait_pc = 1'b0;
                        ex_cnt  = 0;
                        st_cnt  = 0;
                        wr_cnt  = 0;
                    end
                end
            endcase
        end
    end

    // Let the queued program execute; optionally drop run while the last
    // instruction is in FD so it has to finish on its own.
    task automatic run_prog(input bit stop_run);
        int budget;
        run = 1'b1;
        if (stop_run) begin
            budget = 0;
            while (!(state == 2'd1 && exp_q.size() == 1) && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 500) fail_now("timeout_waiting_last_fetch");
            run = 1'b0;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 1000) fail_now("timeout_waiting_drain");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exn;
        int budget;
        int wrseen;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        reset  = 1'b0;
        run    = 1'b0;
        cmp_eq = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_opcode", opcode, 0);
        check("rst_halted", halted, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_imm_sel", imm_sel, 0);
        check("rst_wr_addr", wr_addr, 0);

        // Idle with run low.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_state", state, 0);
            check("idle_pc", pc, 0);
        end

        // LDI, MUL, ADI, JMP, CMPJ taken (backwards), DIV, JMP 0xFF, NOP wrap.
        cmp_eq = 1'b1;
        push(8'h00, 16'h2105, 1, 4'h1, 1'b1, 1, 0, 8'h01, 1'b0);
        push(8'h01, 16'h6123, 1, 4'h3, 1'b0, 4, 1, 8'h02, 1'b0);
        push(8'h02, 16'h4A7F, 1, 4'hA, 1'b1, 1, 0, 8'h03, 1'b0);
        push(8'h03, 16'hE010, 0, 4'h0, 1'b0, 1, 0, 8'h10, 1'b0);
        push(8'h10, 16'hD12E, 0, 4'h0, 1'b0, 1, 0, 8'h0E, 1'b0);
        push(8'h0E, 16'h5321, 1, 4'h1, 1'b0, 4, 1, 8'h0F, 1'b0);
        push(8'h0F, 16'hE0FF, 0, 4'h0, 1'b0, 1, 0, 8'hFF, 1'b0);
        push(8'hFF, 16'h0000, 0, 4'h0, 1'b0, 1, 0, 8'h00, 1'b0);
        run_prog(1'b1);
        repeat (3) @(negedge clk);
        check("stopped_state", state, 0);
        check("stopped_pc", pc, 0);

        // CMPJ not taken, then DEC and NAND.
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        cmp_eq = 1'b0;
        push(8'h00, 16'hE010, 0, 4'h0, 1'b0, 1, 0, 8'h10, 1'b0);
        push(8'h10, 16'hD12E, 0, 4'h0, 1'b0, 1, 0, 8'h11, 1'b0);
        push(8'h11, 16'h7008, 1, 4'h8, 1'b0, 1, 0, 8'h12, 1'b0);
        push(8'h12, 16'hA9BC, 1, 4'hC, 1'b0, 1, 0, 8'h13, 1'b0);
        run_prog(1'b1);

        // Straight-line ops ending in HLT at 0x05, run kept high.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push(8'h00, 16'h8105, 1, 4'h5, 1'b0, 1, 0, 8'h01, 1'b0);
        push(8'h01, 16'h9236, 1, 4'h6, 1'b0, 1, 0, 8'h02, 1'b0);
        push(8'h02, 16'hC347, 1, 4'h7, 1'b0, 1, 0, 8'h03, 1'b0);
        push(8'h03, 16'h0000, 0, 4'h0, 1'b0, 1, 0, 8'h04, 1'b0);
        push(8'h04, 16'hB458, 1, 4'h8, 1'b0, 1, 0, 8'h05, 1'b0);
        push(8'h05, 16'hF000, 0, 4'h0, 1'b0, 1, 0, 8'h05, 1'b1);
        run_prog(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_state", state, 0);
            check("halt_pc", pc, 8'h05);
            check("halt_flag", halted, 1);
        end
        #2 reset = 1'b0;
        #1;
        check("halt_rst_halted", halted, 0);
        check("halt_rst_pc", pc, 0);

        // Reset during a MUL stall that never completes.
        @(negedge clk);
        done_en = 1'b0;
        push(8'h00, 16'h6123, 1, 4'h3, 1'b0, 4, 1, 8'h01, 1'b0);
        reset  = 1'b1;
        exn    = 0;
        budget = 0;
        while (exn < 3 && budget < 50) begin
            @(negedge clk);
            budget++;
            if (state == 2'd2) exn++;
        end
        if (budget >= 50) fail_now("timeout_waiting_ex_stall");
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        check("abort_state", state, 0);
        check("abort_pc", pc, 0);
        check("abort_ir", ir, 0);
        check("abort_alu_start", alu_start, 0);
        wrseen = 0;
        if (wr_en) wrseen++;
        repeat (4) begin
            @(negedge clk);
            if (wr_en) wrseen++;
        end
        check("abort_no_wr_en", wrseen, 0);

        // First fetch after release comes from 0x00.
        done_en = 1'b1;
        push(8'h00, 16'h3456, 1, 4'h6, 1'b0, 1, 0, 8'h01, 1'b0);
        reset = 1'b1;
        run_prog(1'b1);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
